// File: rtl/deadlock_pkg.sv
// Shared types and helpers for the deadlock report unit.
package deadlock_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    REPORT  = 2'd2,
    LATCHED = 2'd3
  } deadlock_state_t;

  localparam int DEADLOCK_HOLD_DEFAULT = 1024;

  // Widest monitor vector the unit supports; callers narrow the index
  // to their own IDX_W.
  localparam int MAX_MON   = 64;
  localparam int MAX_IDX_W = 6;

  // Index of the lowest set bit. Meaningless when mask is zero.
  function automatic logic [MAX_IDX_W-1:0] lowest_set_idx(input logic [MAX_MON-1:0] mask);
    logic [MAX_IDX_W-1:0] idx;
    idx = '0;
    for (int i = MAX_MON - 1; i >= 0; i--) begin
      if (mask[i]) idx = MAX_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/deadlock_prio_enc.sv
// Lowest-set-bit encoder for the monitor block vector.
// Output is only meaningful when mask is nonzero.
module deadlock_prio_enc
  import deadlock_pkg::*;
#(
  parameter int NUM_MON = 8,
  parameter int IDX_W   = (NUM_MON > 1) ? $clog2(NUM_MON) : 1
) (
  input  logic [NUM_MON-1:0] mask,
  output logic [IDX_W-1:0]   idx
);

  logic [MAX_MON-1:0]   mask_ext;
  logic [MAX_IDX_W-1:0] idx_full;

  // Widen to the package function's fixed width, then narrow the result.
  always_comb begin
    mask_ext = '0;
    mask_ext[NUM_MON-1:0] = mask;
    idx_full = lowest_set_idx(mask_ext);
    idx = IDX_W'(idx_full);
  end

endmodule

// File: rtl/deadlock_report_unit.sv
// Deadlock report unit: confirms a persistent monitor block, reports it
// once over valid/ready, and keeps a sticky flag until cleared.
// Optional simulation trace: define DEADLOCK_REPORT_TRACE_EN.
module deadlock_report_unit
  import deadlock_pkg::*;
#(
  parameter int NUM_MON     = 8,
  parameter int IDX_W       = (NUM_MON > 1) ? $clog2(NUM_MON) : 1,
  parameter int CNT_W       = 16,
  parameter int HOLD_CYCLES = DEADLOCK_HOLD_DEFAULT
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_MON-1:0] mon_block,
  input  logic               clear,
  output logic               rpt_valid,
  input  logic               rpt_ready,
  output logic [IDX_W-1:0]   rpt_idx,
  output logic [NUM_MON-1:0] rpt_mask,
  output logic               deadlock,
  output logic [CNT_W-1:0]   blocked_cycles
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_HOLD = CNT_W'(HOLD_CYCLES - 1);

  deadlock_state_t state, state_nxt;

  logic [NUM_MON-1:0] mon_q;
  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   enc_idx;
  logic               any;
  logic               capture;
  logic               drop_valid;
  logic               wipe;
  logic               cnt_zero;

  assign any            = |mon_q;
  assign blocked_cycles = cnt;

  deadlock_prio_enc #(
    .NUM_MON (NUM_MON),
    .IDX_W   (IDX_W)
  ) u_prio_enc (
    .mask (mon_q),
    .idx  (enc_idx)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state and datapath strobes. A clear in IDLE/ARMED beats a
  // confirmation in the same cycle; a clear in REPORT is dropped.
  always_comb begin
    state_nxt  = state;
    capture    = 1'b0;
    drop_valid = 1'b0;
    wipe       = 1'b0;
    cnt_zero   = !any;
    case (state)
      IDLE: begin
        if (clear) begin
          cnt_zero = 1'b1;
        end else if (any) begin
          if (HOLD_CYCLES == 1) begin
            capture   = 1'b1;
            state_nxt = REPORT;
          end else begin
            state_nxt = ARMED;
          end
        end
      end
      ARMED: begin
        if (clear) begin
          cnt_zero  = 1'b1;
          state_nxt = IDLE;
        end else if (!any) begin
          state_nxt = IDLE;
        end else if (cnt == CNT_HOLD) begin
          capture   = 1'b1;
          state_nxt = REPORT;
        end
      end
      REPORT: begin
        if (rpt_valid && rpt_ready) begin
          drop_valid = 1'b1;
          state_nxt  = LATCHED;
        end
      end
      LATCHED: begin
        if (clear) begin
          wipe      = 1'b1;
          cnt_zero  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Input stage, saturating persistence counter and report registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      mon_q     <= '0;
      cnt       <= '0;
      rpt_valid <= 1'b0;
      rpt_idx   <= '0;
      rpt_mask  <= '0;
      deadlock  <= 1'b0;
    end else begin
      mon_q <= mon_block;
      if (cnt_zero)            cnt <= '0;
      else if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
      if (capture) begin
        rpt_valid <= 1'b1;
        deadlock  <= 1'b1;
        rpt_mask  <= mon_q;
        rpt_idx   <= enc_idx;
      end
      if (drop_valid) rpt_valid <= 1'b0;
      if (wipe) begin
        deadlock <= 1'b0;
        rpt_idx  <= '0;
        rpt_mask <= '0;
      end
    end
  end

`ifdef DEADLOCK_REPORT_TRACE_EN
  logic [CNT_W+15:0] trace_cycle;

  // Free-running cycle stamp and report log.
  always_ff @(posedge clock) begin
    if (reset) trace_cycle <= '0;
    else       trace_cycle <= trace_cycle + 1'b1;
    if (!reset && capture)
      $display("%0t deadlock report: cycle=%0d idx=%0d mask=%0h",
               $time, trace_cycle, enc_idx, mon_q);
  end

  // A pending report must stay put until accepted.
  assert property (@(posedge clock) disable iff (reset)
    (rpt_valid && !rpt_ready) |=> (rpt_valid && $stable(rpt_idx) && $stable(rpt_mask)));
`else
`endif

endmodule
